operand_loader: RTL and testbench



---
 rtl/operand_loader.sv | 196 +++++++++++++++++++
 tb/tb_operand_loader.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// operand_loader
//
// Front end for the 4-bit ALU/display block. Slide switches supply a value
// and a debounced "next" button latches it into A, then B, then the opcode.
// The three fields are held on the outputs and drive the ALU directly.
// valid goes high when a complete, legal set is loaded. A level-sensitive
// clear button returns everything to the empty state.
//
// Ports:
//   clock      system clock, rising edge
//   rst        synchronous active-high reset
//   sw[3:0]    slide switches (asynchronous)
//   btn_next   raw "next" push-button (asynchronous, bouncy)
//   btn_clear  raw clear push-button (asynchronous)
//   A[3:0]     latched operand A
//   B[3:0]     latched operand B
//   op[3:0]    latched opcode
//   valid      complete operand set held (state == HOLD)
//   stage[1:0] state code for LEDs: 0 LOAD_A, 1 LOAD_B, 2 LOAD_OP, 3 HOLD
//   op_err     last opcode press was above MAX_OP

module operand_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned MAX_OP          = 12
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_next,
    input  logic       btn_clear,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] op,
    output logic       valid,
    output logic [1:0] stage,
    output logic       op_err
);

    // Counter must be at least one bit wide even when DEBOUNCE_CYCLES == 1.
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StLoadA  = 2'd0,
        StLoadB  = 2'd1,
        StLoadOp = 2'd2,
        StHold   = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Two-flop synchronizers
    // ------------------------------------------------------------------
    logic [3:0] sw_meta_q, sw_s;
    logic       next_meta_q, next_s;
    logic       clear_meta_q, clear_s;

    always_ff @(posedge clock) begin
        if (rst) begin
            sw_meta_q    <= '0;
            sw_s         <= '0;
            next_meta_q  <= 1'b0;
            next_s       <= 1'b0;
            clear_meta_q <= 1'b0;
            clear_s      <= 1'b0;
        end else begin
            sw_meta_q    <= sw;
            sw_s         <= sw_meta_q;
            next_meta_q  <= btn_next;
            next_s       <= next_meta_q;
            clear_meta_q <= btn_clear;
            clear_s      <= clear_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Debounce for btn_next: a new level is accepted only after it has
    // differed from the accepted level for DEBOUNCE_CYCLES straight cycles.
    // Keeps running during clear so a held button is not re-seen later.
    // ------------------------------------------------------------------
    logic            stable_q, stable_d;
    logic            stable_dly_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            press;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (next_s != stable_q) begin
            if (cnt_q == CntMax) begin
                stable_d = next_s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
        end
    end

    // One-cycle pulse per accepted rising edge; release gives nothing.
    assign press = stable_q & ~stable_dly_q;

    // ------------------------------------------------------------------
    // Load sequencer
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] op_q, op_d;
    logic       valid_q, valid_d;
    logic       op_err_q, op_err_d;
    logic       op_legal;

    assign op_legal = (32'(sw_s) <= MAX_OP);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        op_err_d = op_err_q;

        if (clear_s) begin
            // Clear wins over a coincident press, which is simply dropped.
            state_d  = StLoadA;
            a_d      = '0;
            b_d      = '0;
            op_d     = '0;
            op_err_d = 1'b0;
        end else if (press) begin
            unique case (state_q)
                StLoadA: begin
                    a_d     = sw_s;
                    state_d = StLoadB;
                end
                StLoadB: begin
                    b_d     = sw_s;
                    state_d = StLoadOp;
                end
                StLoadOp: begin
                    if (op_legal) begin
                        op_d     = sw_s;
                        op_err_d = 1'b0;
                        state_d  = StHold;
                    end else begin
                        op_err_d = 1'b1;
                    end
                end
                StHold: begin
                    state_d = StLoadA;
                end
                default: begin
                    state_d = StLoadA;
                end
            endcase
        end

        // Registered so it rises on the same edge that latches op.
        valid_d = (state_d == StHold);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q  <= StLoadA;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            valid_q  <= 1'b0;
            op_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            valid_q  <= valid_d;
            op_err_q <= op_err_d;
        end
    end

    assign A      = a_q;
    assign B      = b_q;
    assign op     = op_q;
    assign valid  = valid_q;
    assign stage  = state_q;
    assign op_err = op_err_q;

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: reference model checked every cycle, a table of
// three-press load vectors, hand-written corner sequences and random stimulus.

module tb_operand_loader;

    localparam int unsigned Deb     = 4;
    localparam int unsigned MaxOp   = 12;
    localparam int          MaxEdge = 8191;

    logic       clock;
    logic       rst;
    logic [3:0] sw;
    logic       btn_next;
    logic       btn_clear;
    logic [3:0] A, B, op;
    logic       valid;
    logic [1:0] stage;
    logic       op_err;

    operand_loader #(
        .DEBOUNCE_CYCLES(Deb),
        .MAX_OP         (MaxOp)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .sw       (sw),
        .btn_next (btn_next),
        .btn_clear(btn_clear),
        .A        (A),
        .B        (B),
        .op       (op),
        .valid    (valid),
        .stage    (stage),
        .op_err   (op_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_edge = 0;

    // Raw inputs as sampled at each edge; accepted button level after each edge.
    bit       raw_r [0:MaxEdge];
    bit       raw_n [0:MaxEdge];
    bit       raw_c [0:MaxEdge];
    bit [3:0] raw_sw[0:MaxEdge];
    bit       stab  [0:MaxEdge];
    int       r_edge    = 0;
    int       last_flip = 0;

    // Expected outputs
    logic [3:0] m_a, m_b, m_op;
    logic       m_valid, m_err;
    int         m_state;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, n_edge);
        end
    endtask

    // Synchronized view after edge k: two-edge delay of the raw sample,
    // zero until two edges have passed since the last reset.
    function automatic bit s_next(input int k);
        return (k - 1 > r_edge) ? raw_n[k-1] : 1'b0;
    endfunction
    function automatic bit s_clear(input int k);
        return (k - 1 > r_edge) ? raw_c[k-1] : 1'b0;
    endfunction
    function automatic bit [3:0] s_sw(input int k);
        return (k - 1 > r_edge) ? raw_sw[k-1] : 4'd0;
    endfunction

    task automatic model_step(input int n);
        bit       p, cs, flip;
        bit [3:0] v;
        if (raw_r[n]) begin
            r_edge    = n;
            last_flip = n;
            stab[n]   = 1'b0;
            m_a = 0; m_b = 0; m_op = 0; m_valid = 0; m_err = 0; m_state = 0;
            return;
        end
        // Sequencer acts on what was visible just before this edge.
        p  = stab[n-1] && !stab[n-2];
        cs = s_clear(n - 1);
        v  = s_sw(n - 1);
        if (cs) begin
            m_a = 0; m_b = 0; m_op = 0; m_err = 0; m_state = 0;
        end else if (p) begin
            case (m_state)
                0: begin m_a = v; m_state = 1; end
                1: begin m_b = v; m_state = 2; end
                2: begin
                    if (int'(v) > MaxOp) m_err = 1;
                    else begin m_op = v; m_err = 0; m_state = 3; end
                end
                default: m_state = 0;
            endcase
        end
        m_valid = (m_state == 3);
        // Accepted level flips once the last Deb synchronized samples, all
        // taken since the previous flip/reset, disagree with it.
        flip = 1'b0;
        if (n - int'(Deb) >= last_flip) begin
            flip = 1'b1;
            for (int j = n - int'(Deb); j <= n - 1; j++)
                if (s_next(j) == stab[n-1]) flip = 1'b0;
        end
        stab[n] = flip ? !stab[n-1] : stab[n-1];
        if (flip) last_flip = n;
    endtask

    task automatic tick();
        @(posedge clock);
        n_edge++;
        if (n_edge >= MaxEdge) begin
            $display("FAIL edge_budget: got %0d expected below %0d", n_edge, MaxEdge);
            $fatal(1, "edge budget exhausted");
        end
        raw_r[n_edge]  = rst;
        raw_n[n_edge]  = btn_next;
        raw_c[n_edge]  = btn_clear;
        raw_sw[n_edge] = sw;
        model_step(n_edge);
        #1;
        check("model", {16'd0, A, B, op, valid, stage, op_err},
              {16'd0, m_a, m_b, m_op, m_valid, m_state[1:0], m_err});
        @(negedge clock);
    endtask

    task automatic do_reset();
        rst = 1; btn_next = 0; btn_clear = 0;
        repeat (2) tick();
        rst = 0;
        repeat (3) tick();
    endtask

    task automatic press(input logic [3:0] v, input int hold);
        sw = v;
        btn_next = 1;
        repeat (hold) tick();
        btn_next = 0;
        repeat (10) tick();
    endtask

    // Raise the button and count edges until the selected field shows v.
    task automatic lat_check(input string nm, input int field, input logic [3:0] v);
        int         lat;
        logic [3:0] cur;
        lat = 0;
        sw = v;
        btn_next = 1;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            tick();
            cur = (field == 0) ? A : (field == 1) ? B : op;
            if (cur == v) lat = k;
        end
        check(nm, lat, 7);
        btn_next = 0;
        repeat (10) tick();
    endtask

    task automatic rtick();
        sw = 4'($urandom_range(0, 15));
        tick();
    endtask

    typedef struct {
        logic [3:0] a, b, o;
        logic [3:0] ea, eb, eo;
        logic       ev;
        logic [1:0] es;
        logic       ee;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{a: 3,  b: 5,  o: 3,  ea: 3,  eb: 5,  eo: 3,  ev: 1, es: 3, ee: 0};
        vecs[1] = '{a: 1,  b: 2,  o: 13, ea: 1,  eb: 2,  eo: 0,  ev: 0, es: 2, ee: 1};
        vecs[2] = '{a: 15, b: 0,  o: 12, ea: 15, eb: 0,  eo: 12, ev: 1, es: 3, ee: 0};
        vecs[3] = '{a: 10, b: 9,  o: 15, ea: 10, eb: 9,  eo: 0,  ev: 0, es: 2, ee: 1};
        vecs[4] = '{a: 0,  b: 15, o: 0,  ea: 0,  eb: 15, eo: 0,  ev: 1, es: 3, ee: 0};

        rst = 1; sw = 0; btn_next = 0; btn_clear = 0;
        @(negedge clock);

        // Reset with switches high and the button toggling
        sw = 4'hF;
        btn_next = 1; tick();
        btn_next = 0; tick();
        check("rst_outputs", {A, B, op, valid, stage, op_err}, 16'd0);
        rst = 0;
        repeat (10) tick();
        check("post_rst_outputs", {A, B, op, valid, stage, op_err}, 16'd0);

        // Each field lands exactly 7 edges after its raw press
        lat_check("lat_A", 0, 4'd3);
        lat_check("lat_B", 1, 4'd5);
        lat_check("lat_op", 2, 4'd3);
        check("full_load", {A, B, op, valid, stage, op_err}, {4'd3, 4'd5, 4'd3, 1'b1, 2'd3, 1'b0});

        // Table of three-press loads
        for (int i = 0; i < 5; i++) begin
            do_reset();
            press(vecs[i].a, 8);
            press(vecs[i].b, 8);
            press(vecs[i].o, 8);
            check("vec_A", A, vecs[i].ea);
            check("vec_B", B, vecs[i].eb);
            check("vec_op", op, vecs[i].eo);
            check("vec_valid", valid, vecs[i].ev);
            check("vec_stage", stage, vecs[i].es);
            check("vec_err", op_err, vecs[i].ee);
        end

        // Short glitch ignored, longer pulse latches once
        do_reset();
        press(4'd7, 3);
        check("glitch_stage", stage, 2'd0);
        check("glitch_A", A, 4'd0);
        press(4'd7, 5);
        check("pulse_stage", stage, 2'd1);
        check("pulse_A", A, 4'd7);

        // Illegal then legal opcode
        do_reset();
        press(4'd1, 8);
        press(4'd2, 8);
        press(4'hD, 8);
        check("bad_op_err", op_err, 1'b1);
        check("bad_op_stage", stage, 2'd2);
        check("bad_op_op", op, 4'd0);
        press(4'hC, 8);
        check("good_op_op", op, 4'd12);
        check("good_op_err", op_err, 1'b0);
        check("good_op_valid", valid, 1'b1);

        // Press in HOLD returns to LOAD_A, fields retained
        do_reset();
        press(4'd3, 8);
        press(4'd5, 8);
        press(4'd3, 8);
        press(4'd9, 8);
        check("hold_exit", {A, B, op, valid, stage}, {4'd3, 4'd5, 4'd3, 1'b0, 2'd0});
        press(4'd9, 8);
        check("reload_A", A, 4'd9);

        // Clear coincident with a completing press in LOAD_B
        do_reset();
        press(4'd6, 8);
        sw = 4'd8;
        btn_next = 1;
        repeat (4) tick();
        btn_clear = 1; tick();
        btn_clear = 0; tick();
        tick();
        check("clear_AB", {A, B, op}, 12'd0);
        check("clear_stage", stage, 2'd0);
        repeat (50) tick();
        check("held_no_repeat", stage, 2'd0);
        btn_next = 0;
        repeat (10) tick();
        press(4'd4, 8);
        check("after_clear_stage", stage, 2'd1);
        check("after_clear_A", A, 4'd4);

        // Random stimulus against the model
        for (int e = 0; e < 300; e++) begin
            int k;
            k = $urandom_range(0, 99);
            if (k < 3) begin
                rst = 1;
                repeat ($urandom_range(1, 2)) rtick();
                rst = 0;
            end else if (k < 10) begin
                btn_clear = 1;
                repeat ($urandom_range(1, 3)) rtick();
                btn_clear = 0;
            end else begin
                btn_next = 1;
                repeat ($urandom_range(1, 8)) rtick();
                btn_next = 0;
                repeat ($urandom_range(1, 8)) rtick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
